// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the LC-3b pipeline hazard controller: FSM states and per-stage load/flush pairs.
package pipeline_hazard_ctrl_pkg;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic {HZ_RUN, HZ_DISCARD} lc3b_hz_state_t;

  typedef struct packed {
    logic load;
    logic flush;
  } lc3b_stage_ctrl;

  // PC has no flush and MEM/WB is never flushed, so they carry only a load bit.
  typedef struct packed {
    logic           load_pc;
    lc3b_stage_ctrl if_id;
    lc3b_stage_ctrl id_ex;
    lc3b_stage_ctrl ex_mem;
    logic           load_mem_wb;
  } lc3b_hz_ctrl_t;

  function automatic lc3b_hz_ctrl_t hz_ctrl_fill(input logic load, input logic flush);
    lc3b_hz_ctrl_t c;
    c.load_pc      = load;
    c.if_id.load   = load;
    c.if_id.flush  = flush;
    c.id_ex.load   = load;
    c.id_ex.flush  = flush;
    c.ex_mem.load  = load;
    c.ex_mem.flush = flush;
    c.load_mem_wb  = load;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, stage load/flush controls and perf counters out.
interface pipeline_hazard_ctrl_if #(parameter int CNT_WIDTH = 16);
  import pipeline_hazard_ctrl_pkg::*;

  logic                 imem_req;
  logic                 imem_resp;
  logic                 dmem_req;
  logic                 dmem_resp;
  lc3b_reg              id_sr1;
  lc3b_reg              id_sr2;
  logic                 id_uses_sr1;
  logic                 id_uses_sr2;
  lc3b_reg              ex_dr;
  logic                 ex_is_load;
  logic                 mispredict;
  logic                 load_pc;
  logic                 load_if_id;
  logic                 load_id_ex;
  logic                 load_ex_mem;
  logic                 load_mem_wb;
  logic                 flush_if_id;
  logic                 flush_id_ex;
  logic                 flush_ex_mem;
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    output imem_req, imem_resp, dmem_req, dmem_resp, id_sr1, id_sr2,
           id_uses_sr1, id_uses_sr2, ex_dr, ex_is_load, mispredict,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, stall_cycles, flush_count
  );

  modport slave (
    input  imem_req, imem_resp, dmem_req, dmem_resp, id_sr1, id_sr2,
           id_uses_sr1, id_uses_sr2, ex_dr, ex_is_load, mispredict,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, stall_cycles, flush_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + ONE;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline; controls are combinational from state + inputs.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave bus
);

  lc3b_hz_state_t state_q, state_d;
  lc3b_hz_ctrl_t  ctrl;
  logic           dstall, istall, luse, mp_take;

  assign dstall = bus.dmem_req & ~bus.dmem_resp;
  assign istall = bus.imem_req & ~bus.imem_resp;
  assign luse   = bus.ex_is_load &
                  ((bus.id_uses_sr1 & (bus.id_sr1 == bus.ex_dr)) |
                   (bus.id_uses_sr2 & (bus.id_sr2 == bus.ex_dr)));

  always_comb begin
    ctrl    = hz_ctrl_fill(1'b1, 1'b0);
    state_d = state_q;
    mp_take = 1'b0;
    if (reset) begin
      ctrl = hz_ctrl_fill(1'b0, 1'b1);
    end else if (state_q == HZ_RUN) begin
      if (dstall) begin
        ctrl = hz_ctrl_fill(1'b0, 1'b0);
      end else if (bus.mispredict) begin
        ctrl.if_id.flush  = 1'b1;
        ctrl.id_ex.flush  = 1'b1;
        ctrl.ex_mem.flush = 1'b1;
        mp_take           = 1'b1;
        if (istall) state_d = HZ_DISCARD;
      end else if (istall || luse) begin
        ctrl.load_pc     = 1'b0;
        ctrl.if_id.load  = 1'b0;
        ctrl.id_ex.flush = 1'b1;
      end
    end else begin
      // Wrong-path fetch in flight: PC already holds the redirect target, IF/ID stays empty.
      if (dstall) begin
        ctrl = hz_ctrl_fill(1'b0, 1'b0);
      end else begin
        ctrl.load_pc     = 1'b0;
        ctrl.if_id.load  = 1'b0;
        ctrl.id_ex.flush = 1'b1;
      end
      ctrl.if_id.flush = 1'b1;
      if (bus.imem_resp) state_d = HZ_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= HZ_RUN;
    else       state_q <= state_d;
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~ctrl.load_pc),
    .count (bus.stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mp_take),
    .count (bus.flush_count)
  );

  assign bus.load_pc      = ctrl.load_pc;
  assign bus.load_if_id   = ctrl.if_id.load;
  assign bus.load_id_ex   = ctrl.id_ex.load;
  assign bus.load_ex_mem  = ctrl.ex_mem.load;
  assign bus.load_mem_wb  = ctrl.load_mem_wb;
  assign bus.flush_if_id  = ctrl.if_id.flush;
  assign bus.flush_id_ex  = ctrl.id_ex.flush;
  assign bus.flush_ex_mem = ctrl.ex_mem.flush;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against a rule-level model.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;

  typedef struct packed {
    logic rst, ireq, iresp, dreq, dresp, mp, ld, u1, u2;
    logic [2:0] dr, s1, s2;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  pipeline_hazard_ctrl_if #(.CNT_WIDTH(CW)) hz ();

  pipeline_hazard_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (hz)
  );

  always #5 clk = ~clk;

  // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem}
  logic [7:0] ctl_vec;
  assign ctl_vec = {hz.load_pc, hz.load_if_id, hz.load_id_ex, hz.load_ex_mem, hz.load_mem_wb,
                    hz.flush_if_id, hz.flush_id_ex, hz.flush_ex_mem};

  // Reference model: whether a wrong-path fetch is outstanding, and the two counters.
  bit          m_discard = 1'b0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;
  logic [7:0]  exp_vec, exp_mask;
  bit          exp_mp_take, exp_discard_nxt;

  function automatic stim_t st(input logic r, ireq, iresp, dreq, dresp, mp, ld, u1, u2,
                               input logic [2:0] dr, s1, s2);
    stim_t s;
    s = '{r, ireq, iresp, dreq, dresp, mp, ld, u1, u2, dr, s1, s2};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst;
    hz.imem_req = s.ireq;  hz.imem_resp = s.iresp;
    hz.dmem_req = s.dreq;  hz.dmem_resp = s.dresp;
    hz.mispredict = s.mp;  hz.ex_is_load = s.ld;
    hz.id_uses_sr1 = s.u1; hz.id_uses_sr2 = s.u2;
    hz.ex_dr = s.dr; hz.id_sr1 = s.s1; hz.id_sr2 = s.s2;
    #1;
  endtask

  // Expected controls from the priority rules; a load whose stage is also flushed is don't-care.
  task automatic model_eval();
    bit data_wait, fetch_wait, dep;
    data_wait  = hz.dmem_req && !hz.dmem_resp;
    fetch_wait = hz.imem_req && !hz.imem_resp;
    dep = hz.ex_is_load && ((hz.id_uses_sr1 && hz.id_sr1 == hz.ex_dr) ||
                            (hz.id_uses_sr2 && hz.id_sr2 == hz.ex_dr));
    exp_mp_take = 1'b0;
    exp_discard_nxt = m_discard && !hz.imem_resp;
    if (rst)                      exp_vec = 8'b00000_111;
    else if (data_wait)           exp_vec = m_discard ? 8'b00000_100 : 8'b00000_000;
    else if (m_discard)           exp_vec = 8'b00111_110;
    else if (hz.mispredict) begin
      exp_vec = 8'b11111_111;
      exp_mp_take = 1'b1;
      exp_discard_nxt = fetch_wait;
    end
    else if (fetch_wait || dep)   exp_vec = 8'b00111_010;
    else                          exp_vec = 8'b11111_000;
    exp_mask = ~{1'b0, exp_vec[2:0], 4'b0000};
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_stall = '0; m_flush = '0; m_discard = 1'b0;
    end else begin
      if (!exp_vec[7] && m_stall != '1) m_stall = m_stall + 1'b1;
      if (exp_mp_take && m_flush != '1) m_flush = m_flush + 1'b1;
      m_discard = exp_discard_nxt;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply(st(1,0,0,0,0,0,0,0,0,0,0,0));
    n_chk++;
    if (ctl_vec !== 8'b00000_111) begin
      n_fail++; $display("FAIL reset_c0 ctl=%b want=%b", ctl_vec, 8'b00000_111);
    end
    model_eval(); tick();
    apply(st(1,0,0,0,0,0,0,0,0,0,0,0));
    n_chk++;
    if (ctl_vec !== 8'b00000_111 || hz.stall_cycles !== '0 || hz.flush_count !== '0) begin
      n_fail++; $display("FAIL reset_c1 ctl=%b st=%0d fc=%0d want ctl=00000111 st=0 fc=0",
                         ctl_vec, hz.stall_cycles, hz.flush_count);
    end
    model_eval(); tick();
    apply(st(0,0,0,0,0,0,0,0,0,0,0,0));
    n_chk++;
    if (ctl_vec !== 8'b11111_000 || hz.stall_cycles !== '0) begin
      n_fail++; $display("FAIL reset_release ctl=%b st=%0d want ctl=11111000 st=0",
                         ctl_vec, hz.stall_cycles);
    end
    model_eval(); tick();
  endtask

  task automatic test_dstall();
    stim_t t[$];
    for (int i = 0; i < 4; i++) t.push_back(st(0,0,0,1,0,0,0,0,0,0,0,0));
    t.push_back(st(0,0,0,1,1,0,0,0,0,0,0,0));
    foreach (t[i]) begin
      apply(t[i]); model_eval();
      n_chk++;
      if (((ctl_vec ^ exp_vec) & exp_mask) !== 8'h00) begin
        n_fail++; $display("FAIL dstall[%0d] ctl=%b want=%b", i, ctl_vec, exp_vec);
      end
      tick();
    end
    n_chk++;
    if (hz.stall_cycles !== 4'd4) begin
      n_fail++; $display("FAIL dstall_count got=%0d want=4", hz.stall_cycles);
    end
  endtask

  task automatic test_load_use();
    stim_t t[$];
    t.push_back(st(0,0,0,0,0,0,1,1,0,3,3,5));  // dependent on sr1
    t.push_back(st(0,0,0,0,0,0,0,1,0,3,3,5));  // load moved to MEM
    t.push_back(st(0,0,0,0,0,0,1,0,0,3,3,5));  // sr1 matches but unused
    t.push_back(st(0,0,0,0,0,0,1,0,1,6,1,6));  // dependent on sr2
    foreach (t[i]) begin
      apply(t[i]); model_eval();
      n_chk++;
      if (((ctl_vec ^ exp_vec) & exp_mask) !== 8'h00) begin
        n_fail++; $display("FAIL load_use[%0d] ctl=%b want=%b", i, ctl_vec, exp_vec);
      end
      tick();
    end
    apply(st(0,0,0,0,0,0,1,0,0,3,3,5));
    n_chk++;
    if (hz.load_pc !== 1'b1 || hz.load_if_id !== 1'b1 || hz.flush_id_ex !== 1'b0) begin
      n_fail++; $display("FAIL load_use_unused got pc=%b ifid=%b fidex=%b want 1 1 0",
                         hz.load_pc, hz.load_if_id, hz.flush_id_ex);
    end
    model_eval(); tick();
  endtask

  task automatic test_mispredict_discard();
    stim_t t[$];
    logic [CW-1:0] fc0;
    fc0 = m_flush;
    t.push_back(st(0,1,0,0,0,1,0,0,0,0,0,0));
    t.push_back(st(0,1,0,0,0,0,0,0,0,0,0,0));
    t.push_back(st(0,1,0,0,0,0,0,0,0,0,0,0));
    t.push_back(st(0,1,1,0,0,0,0,0,0,0,0,0));
    t.push_back(st(0,0,0,0,0,0,0,0,0,0,0,0));
    foreach (t[i]) begin
      apply(t[i]); model_eval();
      n_chk++;
      if (((ctl_vec ^ exp_vec) & exp_mask) !== 8'h00) begin
        n_fail++; $display("FAIL mp_discard[%0d] ctl=%b want=%b", i, ctl_vec, exp_vec);
      end
      n_chk++;
      if (hz.flush_count !== m_flush) begin
        n_fail++; $display("FAIL mp_discard_fc[%0d] got=%0d want=%0d", i, hz.flush_count, m_flush);
      end
      tick();
    end
    n_chk++;
    if (hz.flush_count !== fc0 + 1'b1) begin
      n_fail++; $display("FAIL mp_discard_total got=%0d want=%0d", hz.flush_count, fc0 + 1'b1);
    end
  endtask

  task automatic test_mispredict_dstall();
    stim_t t[$];
    t.push_back(st(0,0,0,1,0,1,0,0,0,0,0,0));
    t.push_back(st(0,0,0,1,0,1,0,0,0,0,0,0));
    t.push_back(st(0,0,0,1,1,1,0,0,0,0,0,0));
    t.push_back(st(0,0,0,0,0,0,0,0,0,0,0,0));
    foreach (t[i]) begin
      apply(t[i]); model_eval();
      n_chk++;
      if (((ctl_vec ^ exp_vec) & exp_mask) !== 8'h00) begin
        n_fail++; $display("FAIL mp_dstall[%0d] ctl=%b want=%b", i, ctl_vec, exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_reset_discard();
    stim_t t[$];
    t.push_back(st(0,1,0,0,0,1,0,0,0,0,0,0));
    t.push_back(st(0,1,0,0,0,0,0,0,0,0,0,0));
    t.push_back(st(1,1,0,0,0,0,0,0,0,0,0,0));
    t.push_back(st(0,0,1,0,0,0,0,0,0,0,0,0));
    t.push_back(st(0,0,0,0,0,0,0,0,0,0,0,0));
    foreach (t[i]) begin
      apply(t[i]); model_eval();
      n_chk++;
      if (((ctl_vec ^ exp_vec) & exp_mask) !== 8'h00) begin
        n_fail++; $display("FAIL reset_discard[%0d] ctl=%b want=%b", i, ctl_vec, exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    apply(st(1,0,0,0,0,0,0,0,0,0,0,0)); model_eval(); tick();
    for (int i = 0; i < 20; i++) begin
      apply(st(0,0,0,1,0,0,0,0,0,0,0,0)); model_eval(); tick();
    end
    apply(st(0,0,0,0,0,0,0,0,0,0,0,0));
    n_chk++;
    if (hz.stall_cycles !== 4'd15) begin
      n_fail++; $display("FAIL stall_sat got=%0d want=15", hz.stall_cycles);
    end
    model_eval(); tick();
    for (int i = 0; i < 20; i++) begin
      apply(st(0,0,0,0,0,1,0,0,0,0,0,0)); model_eval(); tick();
    end
    apply(st(0,0,0,0,0,0,0,0,0,0,0,0));
    n_chk++;
    if (hz.flush_count !== 4'd15 || hz.stall_cycles !== 4'd15) begin
      n_fail++; $display("FAIL flush_sat got fc=%0d st=%0d want fc=15 st=15",
                         hz.flush_count, hz.stall_cycles);
    end
    model_eval(); tick();
  endtask

  task automatic test_random();
    stim_t s;
    apply(st(1,0,0,0,0,0,0,0,0,0,0,0)); model_eval(); tick();
    for (int i = 0; i < 400; i++) begin
      s.rst   = ($urandom_range(0, 49) == 0);
      s.ireq  = $urandom_range(0, 1);
      s.iresp = ($urandom_range(0, 2) == 0);
      s.dreq  = ($urandom_range(0, 3) == 0);
      s.dresp = $urandom_range(0, 1);
      s.mp    = ($urandom_range(0, 7) == 0);
      s.ld    = $urandom_range(0, 1);
      s.u1    = $urandom_range(0, 1);
      s.u2    = $urandom_range(0, 1);
      s.dr    = 3'($urandom_range(0, 3));
      s.s1    = 3'($urandom_range(0, 3));
      s.s2    = 3'($urandom_range(0, 3));
      apply(s); model_eval();
      n_chk++;
      if (((ctl_vec ^ exp_vec) & exp_mask) !== 8'h00) begin
        n_fail++; $display("FAIL random[%0d] ctl=%b want=%b", i, ctl_vec, exp_vec);
      end
      n_chk++;
      if (hz.stall_cycles !== m_stall || hz.flush_count !== m_flush) begin
        n_fail++; $display("FAIL random_cnt[%0d] st=%0d fc=%0d want st=%0d fc=%0d",
                           i, hz.stall_cycles, hz.flush_count, m_stall, m_flush);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    apply(st(1,0,0,0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    test_reset();
    test_dstall();
    test_load_use();
    test_mispredict_discard();
    test_mispredict_dstall();
    test_reset_discard();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
